i2c_master_read_byte: RTL and testbench

Byte-level receive engine of the I2C master controller. On a `go` request it drives 8 SCL clock pulses and samples SDA once per bit, MSB first. Each received bit is presented serially on `data` with a one-cycle `load` strobe, and a one-cycle `finish` pulse marks the end of the byte. START/STOP/ACK generation and SDA output drive belong to sibling blocks; this block only drives SCL and only reads SDA.

---
 rtl/i2c_master_read_byte.sv | 114 +++++++++++
 tb/tb_i2c_master_read_byte.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/i2c_master_read_byte.sv
// I2C master byte receiver: drives 8 SCL pulses, samples SDA at mid-high, MSB first.
// Latency: finish pulses 32*QUARTER+1 cycles after go is sampled; load follows each sample by one cycle.
// Backpressure: none; once started the byte always completes, go is only looked at in IDLE.
module i2c_master_read_byte #(
    parameter int QUARTER = 5
) (
    input  logic clock,
    input  logic reset_n,
    input  logic go,
    output logic finish,
    output logic data,
    output logic load,
    output logic scl,
    input  logic sda
);

    localparam int CW = (QUARTER > 1) ? $clog2(2 * QUARTER) : 1;
    localparam logic [CW-1:0] Q_LAST = CW'(2 * QUARTER - 1);
    localparam logic [CW-1:0] Q_MID  = CW'(QUARTER - 1);
    localparam logic [CW-1:0] Q_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [CW-1:0] qcnt, qcnt_nxt;
    logic          scl_nxt, load_nxt, data_nxt, finish_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            qcnt    <= '0;
            scl     <= 1'b0;
            load    <= 1'b0;
            data    <= 1'b0;
            finish  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            qcnt    <= qcnt_nxt;
            scl     <= scl_nxt;
            load    <= load_nxt;
            data    <= data_nxt;
            finish  <= finish_nxt;
        end
    end

    // scl_nxt tracks the state being entered so the registered scl lines up with it.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        qcnt_nxt    = qcnt;
        scl_nxt     = 1'b0;
        load_nxt    = 1'b0;
        data_nxt    = data;
        finish_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt   = LOW;
                    bit_cnt_nxt = 3'd0;
                    qcnt_nxt    = '0;
                end
            end

            LOW: begin
                if (qcnt == Q_LAST) begin
                    state_nxt = HIGH;
                    qcnt_nxt  = '0;
                    scl_nxt   = 1'b1;
                end else begin
                    qcnt_nxt  = qcnt + Q_ONE;
                end
            end

            HIGH: begin
                scl_nxt = 1'b1;
                if (qcnt == Q_MID) begin
                    load_nxt = 1'b1;
                    data_nxt = sda;
                end
                if (qcnt == Q_LAST) begin
                    qcnt_nxt = '0;
                    scl_nxt  = 1'b0;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = DONE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        state_nxt   = LOW;
                    end
                end else begin
                    qcnt_nxt = qcnt + Q_ONE;
                end
            end

            DONE: begin
                finish_nxt = 1'b1;
                state_nxt  = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_read_byte.sv
// Randomized bench for i2c_master_read_byte; expected waveform derived from bit-period arithmetic.
module tb_i2c_master_read_byte;

    localparam int Q      = 5;
    localparam int BIT_T  = 4 * Q;
    localparam int BYTE_T = 32 * Q;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    logic go      = 1'b0;
    logic sda     = 1'b1;
    logic finish, data, load, scl;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    i2c_master_read_byte #(.QUARTER(Q)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .go      (go),
        .finish  (finish),
        .data    (data),
        .load    (load),
        .scl     (scl),
        .sda     (sda)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            check("idle_scl", scl, 0);
            check("idle_load", load, 0);
            check("idle_finish", finish, 0);
        end
    endtask

    // mode 0: slave changes sda once per low phase; 1: toggling slave; 2: sda noise while scl low.
    // Called with go already 1; the first edge inside is the one where IDLE samples go.
    task automatic read_byte(input logic [7:0] pat, input int mode, input bit keep_go, input bit abort);
        logic [7:0] exp_byte;
        logic [7:0] shreg;
        logic       exp_scl, exp_load, exp_fin;
        int         nload, ph, k;
        exp_byte = (mode == 1) ? 8'hAA : pat;
        shreg    = 8'h00;
        nload    = 0;
        if (mode == 1) sda = 1'b1;
        @(posedge clock); #1;
        for (int t = 0; t <= BYTE_T + 1; t++) begin
            if (t > 0) begin
                @(posedge clock); #1;
            end
            ph       = t % BIT_T;
            k        = t / BIT_T;
            exp_scl  = (t < BYTE_T) && (ph >= 2 * Q);
            exp_load = (t < BYTE_T) && (ph == 3 * Q);
            exp_fin  = (t == BYTE_T + 1);
            check("scl", scl, exp_scl);
            check("load", load, exp_load);
            check("finish", finish, exp_fin);
            if (load) begin
                shreg = {shreg[6:0], data};
                nload++;
            end
            if (exp_load) check("data", data, exp_byte[7-k]);

            if (abort && exp_load && k == 3) begin
                #2 reset_n = 1'b0;
                #1;
                check("abort_scl", scl, 0);
                check("abort_load", load, 0);
                check("abort_finish", finish, 0);
                check("abort_data", data, 0);
                go = 1'b0;
                @(posedge clock); #1;
                @(posedge clock); #1;
                reset_n = 1'b1;
                return;
            end

            case (mode)
                0: if (t < BYTE_T && ph == 1) sda = pat[7-k];
                1: if (t < BYTE_T && k >= 1 && ph == 2) sda = ~sda;
                default: begin
                    if (t < BYTE_T && ph < 2 * Q - 1) sda = ~sda;
                    else if (t < BYTE_T && ph == 2 * Q - 1) sda = pat[7-k];
                end
            endcase

            if (t == BYTE_T + 1) go = keep_go;
            else if (!keep_go && t > 0 && t < BYTE_T) go = 1'($urandom_range(0, 1));
        end
        check("nload", nload, 8);
        check("byte", shreg, exp_byte);
    endtask

    initial begin
        bit keep;
        int mode;

        #3 reset_n = 1'b0;
        #1;
        check("rst_scl", scl, 0);
        check("rst_finish", finish, 0);
        check("rst_load", load, 0);
        check("rst_data", data, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle_cycles(200);

        go = 1'b1;
        read_byte(8'hA5, 0, 1'b0, 1'b0);
        idle_cycles(5);

        go = 1'b1;
        read_byte(8'h00, 1, 1'b0, 1'b0);
        idle_cycles(3);

        go = 1'b1;
        read_byte(8'($urandom), 0, 1'b1, 1'b0);
        read_byte(8'($urandom), 0, 1'b0, 1'b0);
        idle_cycles(4);

        go = 1'b1;
        read_byte(8'($urandom), 0, 1'b0, 1'b1);
        idle_cycles(20);
        go = 1'b1;
        read_byte(8'hFF, 0, 1'b0, 1'b0);
        idle_cycles(2);

        go = 1'b1;
        read_byte(8'h00, 2, 1'b0, 1'b0);
        idle_cycles(2);

        keep = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!keep) begin
                idle_cycles($urandom_range(1, 10));
                go = 1'b1;
            end
            keep = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            read_byte(8'($urandom), mode, keep, 1'b0);
        end
        idle_cycles(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
